evt_time_scheduler: RTL and testbench
=====================================

EVT_TIME_SCHEDULER -- requirements
Module: evt_time_scheduler

Interface
REQ-001 Parameter N_ENGINES, default 3, number of engine slices gated by the scheduler.
REQ-002 Parameter TS_W, default 32, timestamp width in bits.
REQ-003 Parameter GAP_CYCLES, default 2, idle cycles forced after each issued time event; range 0..15.
REQ-004 Parameter DRAIN_MAX, default 255, maximum cycles spent waiting for engines to drain; range 1..65535.
REQ-005 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-006 clk_i  input  1  clock; every register updates on its rising edge.
REQ-007 rst_ni  input  1  reset, sampled on clk_i.
REQ-008 in_valid_i  input  1  upstream time/synch event valid.
REQ-009 in_ready_o  output  1  scheduler accepts the upstream event.
REQ-010 in_is_time_i  input  1  1 = EVT_TIME event, 0 = EVT_SYNCH/other event.
REQ-011 in_ts_i  input  TS_W  event timestamp value.
REQ-012 engine_busy_i  input  N_ENGINES  per-engine busy flag, bit k for engine k.
REQ-013 hold_o  output  1  request to all engines to stop accepting new spikes.
REQ-014 out_valid_o  output  1  downstream event valid, to the time unit.
REQ-015 out_ready_i  input  1  downstream ready.
REQ-016 out_is_time_o  output  1  registered copy of in_is_time_i.
REQ-017 out_ts_o  output  TS_W  registered copy of in_ts_i.
REQ-018 last_ts_o  output  TS_W  timestamp of the last issued time event.
REQ-019 step_cnt_o  output  16  count of issued time events; wraps modulo 2^16.
REQ-020 err_timeout_o  output  1  sticky; set when a drain exceeds DRAIN_MAX cycles.
REQ-021 err_order_o  output  1  sticky; set when a time event is not newer than last_ts_o.

Function
REQ-022 The FSM SHALL have the states IDLE, DRAIN, ISSUE and GAP.
REQ-023 IDLE: in_ready_o=1 and all other control outputs 0; on in_valid_i the block latches in_is_time_i and in_ts_i.
REQ-024 IDLE exit: a non-time event goes to ISSUE; a time event with in_ts_i > last_ts_o goes to DRAIN; a time event with in_ts_i <= last_ts_o sets err_order_o, is dropped and stays in IDLE.
REQ-025 The first time event after reset is exempt from the ordering check.
REQ-026 DRAIN: hold_o=1 and in_ready_o=0; the drain counter increments each cycle from 0.
REQ-027 DRAIN exit: if engine_busy_i==0 is sampled, go to ISSUE the next cycle.
REQ-028 DRAIN timeout: if the counter reaches DRAIN_MAX with busy still nonzero, set err_timeout_o and go to ISSUE anyway.
REQ-029 ISSUE: out_valid_o=1 and out_is_time_o/out_ts_o are held stable until out_ready_i; hold_o=1 only for time events.
REQ-030 On the handshake (out_valid_o & out_ready_i) for a time event: last_ts_o <= out_ts_o and step_cnt_o increments.
REQ-031 After the handshake, a time event goes to GAP, or to IDLE when GAP_CYCLES=0; a non-time event goes to IDLE.
REQ-032 GAP: hold_o=0, in_ready_o=0 for exactly GAP_CYCLES cycles, then IDLE.
REQ-033 Throughput: a non-time event passes in a minimum of 2 cycles (IDLE accept, ISSUE).
REQ-034 Throughput: a time event with idle engines passes in a minimum of 3+GAP_CYCLES cycles.
REQ-035 out_valid_o SHALL never deassert before the handshake completes.
REQ-036 engine_busy_i changes during ISSUE or GAP SHALL have no effect.
REQ-037 err_timeout_o and err_order_o clear only on reset.

Reset
REQ-038 With rst_ni=0 at a rising edge, the FSM goes to IDLE and the drain and gap counters clear.
REQ-039 Reset also clears the data registers: last_ts_o=0, step_cnt_o=0, out_ts_o=0 and out_is_time_o=0.
REQ-040 Reset also clears all control outputs and flags: hold_o=0, out_valid_o=0, err_timeout_o=0, err_order_o=0 and the first-event flag; in_ready_o=1 from the first cycle after reset.
REQ-041 Reset asserted mid-DRAIN or mid-ISSUE aborts the event without a handshake; out_valid_o=0 on the next cycle.

Verification
REQ-042 Time ts=5 with busy=000 and out_ready_i=1: hold_o high for 2 cycles, out_ts_o=5, last_ts_o=5, step_cnt_o=1, in_ready_o low for 2 further cycles (GAP_CYCLES=2).
REQ-043 Time ts=10 with busy=010 clearing after 7 cycles: hold_o stays high throughout the drain, ISSUE starts the cycle after busy==0, and err_timeout_o=0.
REQ-044 Busy stuck at 001 with DRAIN_MAX=4: err_timeout_o=1 after 4 DRAIN cycles and the event is still issued.
REQ-045 After last_ts_o=10, send time ts=10 and then ts=3: both are dropped, err_order_o=1, step_cnt_o unchanged and out_valid_o never asserts.
REQ-046 Synch event while out_ready_i is held low for 5 cycles: out_valid_o stays high and stable, hold_o=0, and the block returns to IDLE after the handshake with step_cnt_o unchanged.
REQ-047 Reset asserted in ISSUE, then step_cnt_o at 0xFFFF: reset clears all outputs; one more issued time event wraps step_cnt_o to 0.

Source files
------------

// File: rtl/evt_time_scheduler.sv
// evt_time_scheduler: gates time events so that engines drain before a time step is issued.
//
// Ports:
//   clk_i, rst_ni      clock and synchronous active-low reset
//   in_valid_i/in_ready_o, in_is_time_i, in_ts_i   upstream event (time or synch)
//   engine_busy_i      per-engine busy flags
//   hold_o             asks all engines to stop accepting new spikes
//   out_valid_o/out_ready_i, out_is_time_o, out_ts_o   downstream event to the time unit
//   last_ts_o          timestamp of the last issued time event
//   step_cnt_o         number of issued time events (wraps)
//   err_timeout_o      sticky: a drain ran out of cycles
//   err_order_o        sticky: a time event was not newer than last_ts_o
module evt_time_scheduler #(
    parameter int unsigned N_ENGINES  = 3,
    parameter int unsigned TS_W       = 32,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned DRAIN_MAX  = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_is_time_i,
    input  logic [TS_W-1:0]      in_ts_i,
    input  logic [N_ENGINES-1:0] engine_busy_i,
    output logic                 hold_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_is_time_o,
    output logic [TS_W-1:0]      out_ts_o,
    output logic [TS_W-1:0]      last_ts_o,
    output logic [15:0]          step_cnt_o,
    output logic                 err_timeout_o,
    output logic                 err_order_o
);

    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_MAX - 1);
    // Only meaningful when GAP_CYCLES > 0; the GAP state is skipped otherwise.
    localparam logic [3:0]  GAP_LAST   = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StIssue, StGap} state_e;

    state_e            state_q, state_d;
    logic [15:0]       drain_cnt_q, drain_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              is_time_q, is_time_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [TS_W-1:0]   last_ts_q, last_ts_d;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_order_q, err_order_d;
    logic              first_done_q, first_done_d;
    logic              in_ready_q, in_ready_d;
    logic              hold_q, hold_d;
    logic              out_valid_q, out_valid_d;

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        is_time_d     = is_time_q;
        ts_d          = ts_q;
        last_ts_d     = last_ts_q;
        step_cnt_d    = step_cnt_q;
        err_timeout_d = err_timeout_q;
        err_order_d   = err_order_q;
        first_done_d  = first_done_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    is_time_d = in_is_time_i;
                    ts_d      = in_ts_i;
                    if (!in_is_time_i) begin
                        state_d = StIssue;
                    end else if (!first_done_q || (in_ts_i > last_ts_q)) begin
                        state_d     = StDrain;
                        drain_cnt_d = '0;
                    end else begin
                        // Stale time event: flag it and drop it.
                        err_order_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (engine_busy_i == '0) begin
                    state_d = StIssue;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = StIssue;
                end else begin
                    drain_cnt_d = drain_cnt_q + 16'd1;
                end
            end
            StIssue: begin
                if (out_valid_q && out_ready_i) begin
                    if (is_time_q) begin
                        last_ts_d    = ts_q;
                        step_cnt_d   = step_cnt_q + 16'd1;
                        first_done_d = 1'b1;
                        gap_cnt_d    = '0;
                        state_d      = (GAP_CYCLES == 0) ? StIdle : StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Control outputs are registered, decoded from the next state.
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StIssue);
        hold_d      = (state_d == StDrain) || ((state_d == StIssue) && is_time_d);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            drain_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            is_time_q     <= 1'b0;
            ts_q          <= '0;
            last_ts_q     <= '0;
            step_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
            err_order_q   <= 1'b0;
            first_done_q  <= 1'b0;
            in_ready_q    <= 1'b1;
            hold_q        <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            is_time_q     <= is_time_d;
            ts_q          <= ts_d;
            last_ts_q     <= last_ts_d;
            step_cnt_q    <= step_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_order_q   <= err_order_d;
            first_done_q  <= first_done_d;
            in_ready_q    <= in_ready_d;
            hold_q        <= hold_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign hold_o        = hold_q;
    assign out_valid_o   = out_valid_q;
    assign out_is_time_o = is_time_q;
    assign out_ts_o      = ts_q;
    assign last_ts_o     = last_ts_q;
    assign step_cnt_o    = step_cnt_q;
    assign err_timeout_o = err_timeout_q;
    assign err_order_o   = err_order_q;

endmodule

// File: tb/tb_evt_time_scheduler.sv
// Directed bench for evt_time_scheduler. Two instances share the stimulus: dut uses the
// default parameters, dut_t uses DRAIN_MAX=4 for the drain timeout case.
module tb_evt_time_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_is_time;
    logic [31:0] in_ts;
    logic [2:0]  busy;
    logic        out_ready;

    logic        in_ready, hold, out_valid, out_is_time, err_timeout, err_order;
    logic [31:0] out_ts, last_ts;
    logic [15:0] step_cnt;

    logic        t_in_ready, t_hold, t_out_valid, t_out_is_time, t_err_timeout, t_err_order;
    logic [31:0] t_out_ts, t_last_ts;
    logic [15:0] t_step_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    evt_time_scheduler dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_is_time_i  (in_is_time),
        .in_ts_i       (in_ts),
        .engine_busy_i (busy),
        .hold_o        (hold),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_is_time_o (out_is_time),
        .out_ts_o      (out_ts),
        .last_ts_o     (last_ts),
        .step_cnt_o    (step_cnt),
        .err_timeout_o (err_timeout),
        .err_order_o   (err_order)
    );

    evt_time_scheduler #(
        .DRAIN_MAX (4)
    ) dut_t (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (t_in_ready),
        .in_is_time_i  (in_is_time),
        .in_ts_i       (in_ts),
        .engine_busy_i (busy),
        .hold_o        (t_hold),
        .out_valid_o   (t_out_valid),
        .out_ready_i   (out_ready),
        .out_is_time_o (t_out_is_time),
        .out_ts_o      (t_out_ts),
        .last_ts_o     (t_last_ts),
        .step_cnt_o    (t_step_cnt),
        .err_timeout_o (t_err_timeout),
        .err_order_o   (t_err_order)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_is_time = 1'b0;
        in_ts      = '0;
        busy       = '0;
        out_ready  = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_hold", hold, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_last_ts", last_ts, 0);
        chk("rst_step_cnt", step_cnt, 0);
        chk("rst_errs", {err_timeout, err_order}, 0);

        // Time ts=5, idle engines
        in_valid = 1'b1; in_is_time = 1'b1; in_ts = 32'd5; busy = 3'b000;
        step();
        in_valid = 1'b0;
        chk("t5_drain_hold", hold, 1);
        chk("t5_drain_ready", in_ready, 0);
        chk("t5_drain_valid", out_valid, 0);
        step();
        chk("t5_issue_valid", out_valid, 1);
        chk("t5_issue_hold", hold, 1);
        chk("t5_issue_ts", out_ts, 5);
        chk("t5_issue_is_time", out_is_time, 1);
        step();
        chk("t5_gap1_hold", hold, 0);
        chk("t5_gap1_valid", out_valid, 0);
        chk("t5_gap1_ready", in_ready, 0);
        chk("t5_last_ts", last_ts, 5);
        chk("t5_step_cnt", step_cnt, 1);
        step();
        chk("t5_gap2_ready", in_ready, 0);
        step();
        chk("t5_idle_ready", in_ready, 1);

        // Time ts=10, engine 1 busy for 7 drain cycles
        in_valid = 1'b1; in_is_time = 1'b1; in_ts = 32'd10; busy = 3'b010;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t10_drain_hold", hold, 1);
            chk("t10_drain_valid", out_valid, 0);
        end
        busy = 3'b000;
        step();
        chk("t10_issue_valid", out_valid, 1);
        chk("t10_issue_hold", hold, 1);
        step();
        chk("t10_last_ts", last_ts, 10);
        chk("t10_step_cnt", step_cnt, 2);
        chk("t10_no_timeout", err_timeout, 0);
        step();
        step();
        chk("t10_idle_ready", in_ready, 1);

        // Stale time events ts=10 and ts=3 are dropped
        in_valid = 1'b1; in_is_time = 1'b1; in_ts = 32'd10;
        step();
        chk("ord10_err", err_order, 1);
        chk("ord10_ready", in_ready, 1);
        chk("ord10_valid", out_valid, 0);
        chk("ord10_hold", hold, 0);
        in_ts = 32'd3;
        step();
        in_valid = 1'b0;
        chk("ord3_err", err_order, 1);
        chk("ord3_valid", out_valid, 0);
        step();
        chk("ord_valid_after", out_valid, 0);
        chk("ord_step_cnt", step_cnt, 2);
        chk("ord_last_ts", last_ts, 10);

        // Synch event with out_ready low for 5 cycles; busy changes must not matter
        out_ready = 1'b0;
        in_valid = 1'b1; in_is_time = 1'b0; in_ts = 32'd77;
        step();
        in_valid = 1'b0;
        busy = 3'b111;
        chk("syn_valid", out_valid, 1);
        chk("syn_hold", hold, 0);
        chk("syn_is_time", out_is_time, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("syn_wait_valid", out_valid, 1);
            chk("syn_wait_ts", out_ts, 77);
            chk("syn_wait_hold", hold, 0);
        end
        out_ready = 1'b1;
        busy = 3'b000;
        step();
        chk("syn_done_valid", out_valid, 0);
        chk("syn_done_ready", in_ready, 1);
        chk("syn_step_cnt", step_cnt, 2);
        chk("syn_err_order_sticky", err_order, 1);

        // Drain timeout on dut_t (DRAIN_MAX=4), busy stuck at 001
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_err_order", err_order, 0);
        chk("rst2_step_cnt", step_cnt, 0);
        in_valid = 1'b1; in_is_time = 1'b1; in_ts = 32'd20; busy = 3'b001;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_drain_hold", t_hold, 1);
            chk("to_drain_err", t_err_timeout, 0);
            chk("to_drain_valid", t_out_valid, 0);
        end
        step();
        chk("to_err", t_err_timeout, 1);
        chk("to_issue_valid", t_out_valid, 1);
        chk("to_issue_ts", t_out_ts, 20);
        chk("to_main_no_err", err_timeout, 0);
        chk("to_main_still_drain", hold, 1);
        step();
        chk("to_step_cnt", t_step_cnt, 1);
        chk("to_last_ts", t_last_ts, 20);
        chk("to_err_sticky", t_err_timeout, 1);

        // Reset in ISSUE aborts the event
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        busy = 3'b000; out_ready = 1'b0;
        in_valid = 1'b1; in_is_time = 1'b1; in_ts = 32'd30;
        step();
        in_valid = 1'b0;
        step();
        chk("ri_issue_valid", out_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("ri_valid", out_valid, 0);
        chk("ri_hold", hold, 0);
        chk("ri_ready", in_ready, 1);
        chk("ri_out_ts", out_ts, 0);
        chk("ri_out_is_time", out_is_time, 0);
        chk("ri_last_ts", last_ts, 0);
        chk("ri_step_cnt", step_cnt, 0);
        chk("ri_errs", {err_timeout, err_order}, 0);

        // Preload the step counter to 0xFFFF, then issue ts=0 (first event, exempt from ordering)
        force dut.step_cnt_q = 16'hFFFF;
        step();
        release dut.step_cnt_q;
        out_ready = 1'b1;
        in_valid = 1'b1; in_is_time = 1'b1; in_ts = 32'd0;
        step();
        in_valid = 1'b0;
        chk("wrap_first_exempt", hold, 1);
        chk("wrap_no_order_err", err_order, 0);
        step();
        chk("wrap_issue_valid", out_valid, 1);
        step();
        chk("wrap_step_cnt", step_cnt, 0);
        chk("wrap_last_ts", last_ts, 0);
        chk("wrap_gap_ready", in_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
